mvau_weight_loader: RTL and testbench
=====================================

Name: mvau_weight_loader

Overview:
- Write-side counterpart of the MVAU weight memory.
- Accepts a weight image on an AXI-Stream slave and packs IN_W-bit beats into SIMD*TW-bit words.
- Drives a synchronous write port into the weight memory, addresses 0..WMEM_DEPTH-1, so weights can be reloaded at runtime instead of only via $readmemh.
- Sits beside the MVAU batch unit; the batch unit must not read while busy=1.

Parameters:
- SIMD, 2, input channels processed per cycle (weights per word).
- TW, 1, bits per weight.
- WMEM_DEPTH, 4, number of words per memory.
- WMEM_ADDR_BW, 4, width of the write address.
- IN_W, 1, stream beat width. SIMD*TW must be an integer multiple of IN_W; BEATS = SIMD*TW/IN_W.

Ports:
- aclk, in, 1, main clock; all logic on rising edge.
- aresetn, in, 1, asynchronous active-low reset.
- load_start, in, 1, one-cycle pulse that begins a load.
- s_axis_tdata, in, IN_W, weight stream beat.
- s_axis_tvalid, in, 1, beat valid.
- s_axis_tready, out, 1, beat accepted when tvalid&tready.
- s_axis_tlast, in, 1, marks the final beat of the image.
- wmem_wen, out, 1, write enable.
- wmem_waddr, out, WMEM_ADDR_BW, write address.
- wmem_wdata, out, SIMD*TW, write data.
- busy, out, 1, high from the cycle after load_start is accepted until the cycle after DONE.
- load_done, out, 1, one-cycle pulse when the last word is written.
- load_err, out, 1, sticky tlast-mismatch flag.

Behaviour:
- Reset values: all outputs 0. FSM=IDLE; beat and word counters 0; pack register 0.
- Reset is asynchronous. When asserted mid-load, the partial word is discarded, the in-flight write is cancelled (wen=0), and the FSM returns to IDLE.
- FSM states are IDLE, LOAD, FLUSH and DONE.
- IDLE:
  - tready=0.
  - On load_start=1, go to LOAD and clear the counters and load_err.
- LOAD:
  - tready=1.
  - Each handshake shifts the beat into the pack register LSB-first: beat k lands in bits [(k+1)*IN_W-1 : k*IN_W].
  - When the beat counter is BEATS-1, the handshake completes a word. On the next cycle: wen=1, waddr=word counter, wdata=packed word. The beat counter wraps to 0.
  - Latency is exactly 1 cycle from the final-beat handshake to the wen pulse. wen is never high for two writes to the same address.
  - Back-to-back words at full rate are supported: one beat per cycle.
  - The word that completes at address WMEM_DEPTH-1 moves the FSM to FLUSH and drops tready on the next cycle.
- FLUSH:
  - Lasts 1 cycle, during which the final wen is issued.
  - Then go to DONE.
- DONE:
  - load_done=1 for 1 cycle, then IDLE.
  - busy falls together with the transition to IDLE.
- load_start is ignored while busy=1.
- tvalid=0 mid-word stalls with no state change.
- IN_W == SIMD*TW (BEATS=1) is legal: every handshake produces a write.
- WMEM_DEPTH=1 is legal.
- Stream beats beyond the image are not consumed: tready is 0 outside LOAD.

Optional Feature:
- Macro: MVAU_WLOAD_TLAST_CHECK_EN.
- Defined:
  - tlast=1 on any beat other than the final beat of word WMEM_DEPTH-1 sets load_err. The load continues to completion.
  - tlast=0 on the final beat also sets load_err.
  - load_err holds until the next accepted load_start or reset.
- Undefined: s_axis_tlast is ignored and load_err is tied to 0.

Decomposition:
- Package mvau_wload_pkg holds:
  - the state enum type (IDLE, LOAD, FLUSH, DONE);
  - the function beats_per_word(SIMD, TW, IN_W);
  - an elaboration-time check function for SIMD*TW % IN_W == 0.
- Sub-module mvau_wload_packer (shift/pack register plus beat counter, outputs word_valid) is natural.
- The FSM, address counter and write port stay in the top module.

Test Plan:
1. SIMD=2, TW=4, IN_W=4, DEPTH=4.
   - Stimulus: load_start, then continuous beats 1,2,3,4,5,6,7,8 with tlast on the 8th.
   - Response: writes (0,0x21), (1,0x43), (2,0x65), (3,0x87), each 1 cycle after its second beat; load_done 2 cycles after the last handshake; load_err=0.
2. Same configuration, tvalid toggled 1,0,1,0 per beat.
   - Response: same four writes with stalls; no duplicate wen; tready stays 1 in LOAD.
3. aresetn pulled low after beat 3 of test 1.
   - Response: wen=0 and busy=0 immediately (asynchronous).
   - After release, a new load writes addr 0 first with fresh data 0xA9 from beats 9,A.
4. load_start pulsed again mid-load.
   - Response: ignored; address sequence continues 0..3 unchanged.
5. MVAU_WLOAD_TLAST_CHECK_EN defined, tlast on beat 4.
   - Response: load_err=1 from the cycle after beat 4; all 4 words still written; load_err cleared by the next load_start.
6. BEATS=1 (IN_W=8), DEPTH=1.
   - Stimulus: beat 0x5C.
   - Response: single write (0,0x5C) in the cycle after the handshake; tready=0 thereafter; load_done pulse.

Source files
------------

// File: rtl/mvau_weight_loader_pkg.sv
// Shared types and elaboration helpers for the MVAU weight loader.
package mvau_wload_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wload_state_e;

    function automatic int beats_per_word(input int simd, input int tw, input int in_w);
        return (simd * tw) / in_w;
    endfunction

    // A word must be built from a whole number of stream beats.
    function automatic bit width_cfg_ok(input int simd, input int tw, input int in_w);
        return (in_w > 0) && (((simd * tw) % in_w) == 0);
    endfunction

endpackage

// File: rtl/mvau_weight_loader_if.sv
// AXI-Stream beat channel feeding the weight loader.
interface mvau_weight_loader_if #(
    parameter int DATA_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mvau_weight_loader_packer.sv
// Packs IN_W-bit beats LSB-first into one WORD_W-bit word; flags the completing beat.
module mvau_wload_packer #(
    parameter int IN_W   = 1,
    parameter int WORD_W = 2,
    parameter int BEATS  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat_fire,
    input  logic [IN_W-1:0]   beat_data,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]     beat_cnt_r;
    logic [WORD_W-1:0] pack_r;
    logic [WORD_W-1:0] pack_next_s;
    logic              last_beat_s;

    // Insert the current beat into its slot of the word under construction.
    always_comb begin
        pack_next_s = pack_r;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt_r == CW'(k)) begin
                pack_next_s[k*IN_W +: IN_W] = beat_data;
            end else begin
                pack_next_s[k*IN_W +: IN_W] = pack_r[k*IN_W +: IN_W];
            end
        end
        last_beat_s = (beat_cnt_r == CW'(BEATS - 1));
    end

    assign word_done = beat_fire & last_beat_s;
    assign word      = pack_next_s;

    // Beat counter and partial-word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= '0;
            pack_r     <= '0;
        end else if (clear) begin
            beat_cnt_r <= '0;
            pack_r     <= '0;
        end else if (beat_fire) begin
            beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + CW'(1);
            pack_r     <= last_beat_s ? '0 : pack_next_s;
        end else begin
            beat_cnt_r <= beat_cnt_r;
            pack_r     <= pack_r;
        end
    end

endmodule

// File: rtl/mvau_weight_loader.sv
// Streams a weight image into the MVAU weight memory write port.
// Optional tlast consistency checking is enabled with MVAU_WLOAD_TLAST_CHECK_EN.
module mvau_weight_loader
    import mvau_wload_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int IN_W         = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    load_start,
    mvau_weight_loader_if.slave     s_axis,
    output logic                    wmem_wen,
    output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
    output logic [SIMD*TW-1:0]      wmem_wdata,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);
    localparam int WORD_W = SIMD * TW;
    localparam int BEATS  = beats_per_word(SIMD, TW, IN_W);

    if (!width_cfg_ok(SIMD, TW, IN_W)) begin : g_cfg_check
        $error("mvau_weight_loader: SIMD*TW must be a multiple of IN_W");
    end

    wload_state_e            state_r;
    wload_state_e            state_next_s;
    logic                    start_s;
    logic                    fire_s;
    logic                    word_done_s;
    logic                    last_word_s;
    logic [WORD_W-1:0]       word_s;
    logic [WMEM_ADDR_BW-1:0] word_cnt_r;
    logic                    wen_r;
    logic [WMEM_ADDR_BW-1:0] waddr_r;
    logic [WORD_W-1:0]       wdata_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    tready_r;

    assign fire_s      = s_axis.tvalid & tready_r;
    assign last_word_s = (word_cnt_r == WMEM_ADDR_BW'(WMEM_DEPTH - 1));

    mvau_wload_packer #(
        .IN_W   (IN_W),
        .WORD_W (WORD_W),
        .BEATS  (BEATS)
    ) u_packer (
        .clk       (aclk),
        .rst_n     (aresetn),
        .clear     (start_s),
        .beat_fire (fire_s),
        .beat_data (s_axis.tdata),
        .word_done (word_done_s),
        .word      (word_s)
    );

    // Next-state logic; a start pulse is only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_next_s = LOAD;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (word_done_s && last_word_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = LOAD;
                end
            end
            FLUSH:   state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, status flags and the write port; all outputs come straight from flops.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= IDLE;
            word_cnt_r <= '0;
            wen_r      <= 1'b0;
            waddr_r    <= '0;
            wdata_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tready_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            busy_r   <= (state_next_s != IDLE);
            tready_r <= (state_next_s == LOAD);
            done_r   <= (state_next_s == DONE);
            wen_r    <= word_done_s;
            if (word_done_s) begin
                waddr_r    <= word_cnt_r;
                wdata_r    <= word_s;
                word_cnt_r <= word_cnt_r + WMEM_ADDR_BW'(1);
            end else if (start_s) begin
                word_cnt_r <= '0;
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    assign s_axis.tready = tready_r;
    assign wmem_wen      = wen_r;
    assign wmem_waddr    = waddr_r;
    assign wmem_wdata    = wdata_r;
    assign busy          = busy_r;
    assign load_done     = done_r;

`ifdef MVAU_WLOAD_TLAST_CHECK_EN
    logic err_r;
    logic err_hit_s;

    // tlast must appear on exactly the last beat of the last word.
    assign err_hit_s = fire_s & (s_axis.tlast != (word_done_s & last_word_s));

    // Sticky mismatch flag, cleared by an accepted start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_r <= 1'b0;
        end else if (start_s) begin
            err_r <= 1'b0;
        end else if (err_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign load_err = err_r;
`else
    logic unused_tlast_s;
    assign unused_tlast_s = s_axis.tlast;
    assign load_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench: config A (SIMD=2,TW=4,IN_W=4,DEPTH=4) and config B (IN_W=8,DEPTH=1).
module tb_mvau_weight_loader;

`ifdef MVAU_WLOAD_TLAST_CHECK_EN
    localparam logic TC = 1'b1;
`else
    localparam logic TC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n, start_a, start_b;
    logic       wen_a, busy_a, done_a, err_a;
    logic [3:0] waddr_a;
    logic [7:0] wdata_a;
    logic       wen_b, busy_b, done_b, err_b;
    logic [3:0] waddr_b;
    logic [7:0] wdata_b;

    mvau_weight_loader_if #(.DATA_W(4)) axis_a ();
    mvau_weight_loader_if #(.DATA_W(8)) axis_b ();

    mvau_weight_loader #(.SIMD(2), .TW(4), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4), .IN_W(4)) dut_a (
        .aclk(clk), .aresetn(rst_a_n), .load_start(start_a), .s_axis(axis_a.slave),
        .wmem_wen(wen_a), .wmem_waddr(waddr_a), .wmem_wdata(wdata_a),
        .busy(busy_a), .load_done(done_a), .load_err(err_a)
    );

    mvau_weight_loader #(.SIMD(2), .TW(4), .WMEM_DEPTH(1), .WMEM_ADDR_BW(4), .IN_W(8)) dut_b (
        .aclk(clk), .aresetn(rst_b_n), .load_start(start_b), .s_axis(axis_b.slave),
        .wmem_wen(wen_b), .wmem_waddr(waddr_b), .wmem_wdata(wdata_b),
        .busy(busy_b), .load_done(done_b), .load_err(err_b)
    );

    typedef struct {
        logic       st;
        logic       vl;
        logic [3:0] d;
        logic       lt;
        logic       rdy;
        logic       wen;
        logic [3:0] a;
        logic [7:0] wd;
        logic       bsy;
        logic       dn;
        logic       er;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic vl, logic [3:0] d, logic lt, logic rdy, logic wen,
                                logic [3:0] a, logic [7:0] wd, logic bsy, logic dn, logic er);
        vec_t t;
        t.st = st; t.vl = vl; t.d = d; t.lt = lt; t.rdy = rdy; t.wen = wen;
        t.a = a; t.wd = wd; t.bsy = bsy; t.dn = dn; t.er = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs on A, clock it, then compare A's outputs.
    task automatic apply_a(input vec_t t, input string tag);
        start_a = t.st; axis_a.tvalid = t.vl; axis_a.tdata = t.d; axis_a.tlast = t.lt;
        @(posedge clk); #1;
        chk({tag, " tready"}, 32'(axis_a.tready), 32'(t.rdy));
        chk({tag, " wen"},    32'(wen_a),  32'(t.wen));
        chk({tag, " busy"},   32'(busy_a), 32'(t.bsy));
        chk({tag, " done"},   32'(done_a), 32'(t.dn));
        chk({tag, " err"},    32'(err_a),  32'(t.er));
        if (t.wen) begin
            chk({tag, " waddr"}, 32'(waddr_a), 32'(t.a));
            chk({tag, " wdata"}, 32'(wdata_a), 32'(t.wd));
        end
    endtask

    // Same as apply_a for the single-beat, single-word config B.
    task automatic apply_b(input logic st, input logic vl, input logic [7:0] d, input logic lt,
                           input logic rdy, input logic wen, input logic [7:0] wd,
                           input logic bsy, input logic dn, input logic er, input string tag);
        start_b = st; axis_b.tvalid = vl; axis_b.tdata = d; axis_b.tlast = lt;
        @(posedge clk); #1;
        chk({tag, " tready"}, 32'(axis_b.tready), 32'(rdy));
        chk({tag, " wen"},    32'(wen_b),  32'(wen));
        chk({tag, " busy"},   32'(busy_b), 32'(bsy));
        chk({tag, " done"},   32'(done_b), 32'(dn));
        chk({tag, " err"},    32'(err_b),  32'(er));
        if (wen) begin
            chk({tag, " waddr"}, 32'(waddr_b), 32'd0);
            chk({tag, " wdata"}, 32'(wdata_b), 32'(wd));
        end
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        axis_a.tvalid = 1'b0; axis_a.tdata = 4'h0; axis_a.tlast = 1'b0;
        axis_b.tvalid = 1'b0; axis_b.tdata = 8'h00; axis_b.tlast = 1'b0;

        // Continuous load, words 0x21,0x43,0x65,0x87
        vecs.push_back(mk(1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h1,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h2,1'b0, 1'b1,1'b1,4'd0,8'h21,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h3,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h4,1'b0, 1'b1,1'b1,4'd1,8'h43,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h5,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h6,1'b0, 1'b1,1'b1,4'd2,8'h65,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h7,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h8,1'b1, 1'b0,1'b1,4'd3,8'h87,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0));
        // Early tlast on beat 4: sticky error when checking is built in
        vecs.push_back(mk(1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h1,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h2,1'b0, 1'b1,1'b1,4'd0,8'h21,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h3,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h4,1'b1, 1'b1,1'b1,4'd1,8'h43,1'b1,1'b0,TC));
        vecs.push_back(mk(1'b0,1'b1,4'h5,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,TC));
        vecs.push_back(mk(1'b0,1'b1,4'h6,1'b0, 1'b1,1'b1,4'd2,8'h65,1'b1,1'b0,TC));
        vecs.push_back(mk(1'b0,1'b1,4'h7,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,TC));
        vecs.push_back(mk(1'b0,1'b1,4'h8,1'b1, 1'b0,1'b1,4'd3,8'h87,1'b1,1'b0,TC));
        vecs.push_back(mk(1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,TC));
        vecs.push_back(mk(1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,TC));
        // Repeated load_start while busy is ignored; start itself clears the error
        vecs.push_back(mk(1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h1,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h2,1'b0, 1'b1,1'b1,4'd0,8'h21,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'h3,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h4,1'b0, 1'b1,1'b1,4'd1,8'h43,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h5,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,4'h6,1'b0, 1'b1,1'b1,4'd2,8'h65,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h7,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,4'h8,1'b1, 1'b0,1'b1,4'd3,8'h87,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0));
        // tvalid toggling 1,0,...; stalled beats carry junk data and tlast
        vecs.push_back(mk(1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
        for (int k = 0; k < 8; k++) begin
            logic       w;
            logic [3:0] d;
            logic [7:0] wd;
            w  = (k % 2 == 1);
            d  = 4'(k + 1);
            wd = {d, 4'(k)};
            vecs.push_back(mk(1'b0,1'b1,d,(k == 7), (k != 7),w,4'(k / 2),wd,1'b1,1'b0,1'b0));
            if (k != 7) begin
                vecs.push_back(mk(1'b0,1'b0,4'hF,1'b1, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0));
            end
        end
        vecs.push_back(mk(1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0));

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst A wen",   32'(wen_a),   32'd0);
        chk("rst A waddr", 32'(waddr_a), 32'd0);
        chk("rst A wdata", 32'(wdata_a), 32'd0);
        chk("rst A busy",  32'(busy_a),  32'd0);
        chk("rst A done",  32'(done_a),  32'd0);
        chk("rst A err",   32'(err_a),   32'd0);
        chk("rst A tready",32'(axis_a.tready), 32'd0);
        chk("rst B wen",   32'(wen_b),   32'd0);
        chk("rst B busy",  32'(busy_b),  32'd0);
        chk("rst B tready",32'(axis_b.tready), 32'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // Idle: beats offered without a start are not accepted
        apply_a(mk(1'b0,1'b1,4'h9,1'b0, 1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0), "idle");

        for (int i = 0; i < vecs.size(); i++) begin
            apply_a(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset while a write is on the port cancels it immediately
        apply_a(mk(1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0), "r1 start");
        apply_a(mk(1'b0,1'b1,4'h1,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0), "r1 b1");
        apply_a(mk(1'b0,1'b1,4'h2,1'b0, 1'b1,1'b1,4'd0,8'h21,1'b1,1'b0,1'b0), "r1 b2");
        axis_a.tvalid = 1'b0;
        #2 rst_a_n = 1'b0;
        #1;
        chk("r1 wen",    32'(wen_a),  32'd0);
        chk("r1 busy",   32'(busy_a), 32'd0);
        chk("r1 tready", 32'(axis_a.tready), 32'd0);
        @(posedge clk); #1 rst_a_n = 1'b1;

        // Reset after beat 3 discards the partial word
        apply_a(mk(1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0), "r2 start");
        apply_a(mk(1'b0,1'b1,4'h1,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0), "r2 b1");
        apply_a(mk(1'b0,1'b1,4'h2,1'b0, 1'b1,1'b1,4'd0,8'h21,1'b1,1'b0,1'b0), "r2 b2");
        apply_a(mk(1'b0,1'b1,4'h3,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0), "r2 b3");
        axis_a.tvalid = 1'b0;
        #2 rst_a_n = 1'b0;
        #1;
        chk("r2 wen",  32'(wen_a),  32'd0);
        chk("r2 busy", 32'(busy_a), 32'd0);
        @(posedge clk); #1 rst_a_n = 1'b1;
        apply_a(mk(1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0), "r2 restart");
        apply_a(mk(1'b0,1'b1,4'h9,1'b0, 1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0), "r2 b9");
        apply_a(mk(1'b0,1'b1,4'hA,1'b0, 1'b1,1'b1,4'd0,8'hA9,1'b1,1'b0,1'b0), "r2 bA");

        // Config B: one beat per word, one word per image
        apply_b(1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b1,1'b0,1'b0, "B start");
        apply_b(1'b0,1'b1,8'h5C,1'b0, 1'b0,1'b1,8'h5C,1'b1,1'b0,TC,   "B beat");
        apply_b(1'b0,1'b1,8'h77,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b1,TC,   "B flush");
        apply_b(1'b0,1'b1,8'h77,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0,TC,   "B idle");
        apply_b(1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b1,1'b0,1'b0, "B start2");
        apply_b(1'b0,1'b1,8'hA5,1'b1, 1'b0,1'b1,8'hA5,1'b1,1'b0,1'b0, "B beat2");
        apply_b(1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b1,1'b0, "B flush2");
        apply_b(1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, "B idle2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
